// File: rtl/bcrypt_job_loader_if.sv
// Stream-in, stream-out and core-memory bus signals of the bcrypt job loader.
// The loader connects through the master modport; the memory/stream side uses slave.
interface bcrypt_job_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;

    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    logic [1:0]  mem_sel;
    logic [6:0]  mem_core;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_req;
    logic        mem_wr_ack;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  s_data, s_valid, s_last, m_ready, mem_wr_ack, mem_rd_ack, mem_rdata,
        output s_ready, m_data, m_valid, m_last,
        output mem_sel, mem_core, mem_addr, mem_wdata, mem_wr_req, mem_rd_req
    );

    modport slave (
        output s_data, s_valid, s_last, m_ready, mem_wr_ack, mem_rd_ack, mem_rdata,
        input  s_ready, m_data, m_valid, m_last,
        input  mem_sel, mem_core, mem_addr, mem_wdata, mem_wr_req, mem_rd_req
    );
endinterface

// File: rtl/bcrypt_job_loader.sv
// Streams a job into every bcrypt core, starts and polls them, then streams results back.
// Optional poll timeout enabled by defining BCRYPT_LOADER_TIMEOUT_EN.
module bcrypt_job_loader #(
    parameter int NUM_CORES     = 28,
    parameter int LOAD_WORDS    = 64,
    parameter int RESULT_BASE   = 64,
    parameter int RESULT_WORDS  = 6,
    parameter int POLL_GAP      = 16,
    parameter int TIMEOUT_POLLS = 65535
) (
    input  logic                   Bus2IP_Clk,
    input  logic                   Bus2IP_Reset,
    bcrypt_job_loader_if.master    bus,
    output logic                   busy,
    output logic                   proto_err,
    output logic                   timeout
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD_WAIT = 4'd1;
    localparam logic [3:0] S_LOAD_WR   = 4'd2;
    localparam logic [3:0] S_START     = 4'd3;
    localparam logic [3:0] S_POLL_GAP  = 4'd4;
    localparam logic [3:0] S_POLL_RD   = 4'd5;
    localparam logic [3:0] S_DRAIN_RD  = 4'd6;
    localparam logic [3:0] S_DRAIN_OUT = 4'd7;
    localparam logic [3:0] S_FAULT     = 4'd8;

    localparam logic [6:0] LAST_CORE = 7'(NUM_CORES - 1);
    localparam logic [6:0] LAST_LOAD = 7'(LOAD_WORDS - 1);
    localparam logic [6:0] LAST_RES  = 7'(RESULT_WORDS - 1);
    localparam logic [6:0] RES_BASE  = 7'(RESULT_BASE);
    localparam int         GAP_W     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(POLL_GAP - 1);

    if (NUM_CORES < 1 || NUM_CORES > 128 || LOAD_WORDS < 1 || LOAD_WORDS > 128 ||
        RESULT_WORDS < 1 || RESULT_BASE + RESULT_WORDS > 128 || POLL_GAP < 1 ||
        TIMEOUT_POLLS < 1 || TIMEOUT_POLLS > 65535) begin : g_bad_params
        $error("bcrypt_job_loader: parameter out of range");
    end

    logic [3:0]       state_reg, state_next;
    logic [6:0]       word_reg, word_next;
    logic [6:0]       core_reg, core_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [1:0]       mem_sel_reg, mem_sel_next;
    logic [6:0]       mem_core_reg, mem_core_next;
    logic [6:0]       mem_addr_reg, mem_addr_next;
    logic [31:0]      mem_wdata_reg, mem_wdata_next;
    logic             mem_wr_req_reg, mem_wr_req_next;
    logic             mem_rd_req_reg, mem_rd_req_next;
    logic [31:0]      m_data_reg, m_data_next;
    logic             m_valid_reg, m_valid_next;
    logic             m_last_reg, m_last_next;
    logic             s_ready_reg, s_ready_next;
    logic             busy_reg, busy_next;
    logic             proto_err_reg, proto_err_next;
`ifdef BCRYPT_LOADER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_POLLS);
    logic [15:0]      poll_cnt_reg, poll_cnt_next;
    logic             timeout_reg, timeout_next;
`endif

    // IDLE always starts a job at (core 0, word 0) regardless of leftover indices.
    logic [6:0] acc_word, acc_core;
    logic       accept, acc_final, load_final, res_final;
    assign acc_word   = (state_reg == S_IDLE) ? 7'd0 : word_reg;
    assign acc_core   = (state_reg == S_IDLE) ? 7'd0 : core_reg;
    assign accept     = bus.s_valid && s_ready_reg;
    assign acc_final  = (acc_core == LAST_CORE) && (acc_word == LAST_LOAD);
    assign load_final = (core_reg == LAST_CORE) && (word_reg == LAST_LOAD);
    assign res_final  = (core_reg == LAST_CORE) && (word_reg == LAST_RES);

    always_comb begin
        state_next      = state_reg;
        word_next       = word_reg;
        core_next       = core_reg;
        gap_next        = gap_reg;
        mem_sel_next    = mem_sel_reg;
        mem_core_next   = mem_core_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_wr_req_next = mem_wr_req_reg;
        mem_rd_req_next = mem_rd_req_reg;
        m_data_next     = m_data_reg;
        m_valid_next    = m_valid_reg;
        m_last_next     = m_last_reg;
        proto_err_next  = proto_err_reg;
`ifdef BCRYPT_LOADER_TIMEOUT_EN
        poll_cnt_next   = poll_cnt_reg;
        timeout_next    = timeout_reg;
`endif

        case (state_reg)
            S_IDLE, S_LOAD_WAIT: begin
                if (accept) begin
                    word_next       = acc_word;
                    core_next       = acc_core;
                    mem_sel_next    = 2'b10;
                    mem_core_next   = acc_core;
                    mem_addr_next   = acc_word;
                    mem_wdata_next  = bus.s_data;
                    mem_wr_req_next = 1'b1;
                    state_next      = S_LOAD_WR;
                    if (bus.s_last != acc_final)
                        proto_err_next = 1'b1;
                end
            end
            S_LOAD_WR: begin
                if (bus.mem_wr_ack) begin
                    mem_wr_req_next = 1'b0;
                    mem_sel_next    = 2'b00;
                    if (load_final) begin
                        state_next = S_START;
                    end else begin
                        state_next = S_LOAD_WAIT;
                        if (word_reg == LAST_LOAD) begin
                            word_next = 7'd0;
                            core_next = core_reg + 7'd1;
                        end else begin
                            word_next = word_reg + 7'd1;
                        end
                    end
                end
            end
            S_START: begin
                // Request is raised one cycle after the last load ack so the bus sees a gap.
                if (!mem_wr_req_reg) begin
                    mem_sel_next    = 2'b01;
                    mem_core_next   = 7'd0;
                    mem_addr_next   = 7'd0;
                    mem_wdata_next  = 32'h1;
                    mem_wr_req_next = 1'b1;
`ifdef BCRYPT_LOADER_TIMEOUT_EN
                    poll_cnt_next   = 16'd0;
`endif
                end else if (bus.mem_wr_ack) begin
                    mem_wr_req_next = 1'b0;
                    mem_sel_next    = 2'b00;
                    gap_next        = '0;
                    state_next      = S_POLL_GAP;
                end
            end
            S_POLL_GAP: begin
                if (gap_reg == LAST_GAP) begin
                    mem_sel_next    = 2'b01;
                    mem_core_next   = 7'd0;
                    mem_addr_next   = 7'd1;
                    mem_rd_req_next = 1'b1;
                    state_next      = S_POLL_RD;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            S_POLL_RD: begin
                if (bus.mem_rd_ack) begin
                    mem_rd_req_next = 1'b0;
                    mem_sel_next    = 2'b00;
                    gap_next        = '0;
                    if (bus.mem_rdata == 32'hFF) begin
                        word_next  = 7'd0;
                        core_next  = 7'd0;
                        state_next = S_DRAIN_RD;
                    end else begin
`ifdef BCRYPT_LOADER_TIMEOUT_EN
                        poll_cnt_next = poll_cnt_reg + 16'd1;
                        if (poll_cnt_next == TIMEOUT_LIMIT) begin
                            timeout_next = 1'b1;
                            state_next   = S_FAULT;
                        end else begin
                            state_next = S_POLL_GAP;
                        end
`else
                        state_next = S_POLL_GAP;
`endif
                    end
                end
            end
            S_DRAIN_RD: begin
                if (!mem_rd_req_reg) begin
                    mem_sel_next    = 2'b10;
                    mem_core_next   = core_reg;
                    mem_addr_next   = RES_BASE + word_reg;
                    mem_rd_req_next = 1'b1;
                end else if (bus.mem_rd_ack) begin
                    mem_rd_req_next = 1'b0;
                    mem_sel_next    = 2'b00;
                    m_data_next     = bus.mem_rdata;
                    m_valid_next    = 1'b1;
                    m_last_next     = res_final;
                    state_next      = S_DRAIN_OUT;
                end
            end
            S_DRAIN_OUT: begin
                if (bus.m_ready) begin
                    m_valid_next = 1'b0;
                    m_last_next  = 1'b0;
                    if (res_final) begin
                        state_next = S_IDLE;
                    end else begin
                        if (word_reg == LAST_RES) begin
                            word_next = 7'd0;
                            core_next = core_reg + 7'd1;
                        end else begin
                            word_next = word_reg + 7'd1;
                        end
                        // Issue the next read straight away to keep two cycles per word.
                        mem_sel_next    = 2'b10;
                        mem_core_next   = core_next;
                        mem_addr_next   = RES_BASE + word_next;
                        mem_rd_req_next = 1'b1;
                        state_next      = S_DRAIN_RD;
                    end
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        s_ready_next = (state_next == S_IDLE) || (state_next == S_LOAD_WAIT);
        busy_next    = (state_next != S_IDLE);
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_reg      <= S_IDLE;
            word_reg       <= 7'd0;
            core_reg       <= 7'd0;
            gap_reg        <= '0;
            mem_sel_reg    <= 2'b00;
            mem_core_reg   <= 7'd0;
            mem_addr_reg   <= 7'd0;
            mem_wdata_reg  <= 32'd0;
            mem_wr_req_reg <= 1'b0;
            mem_rd_req_reg <= 1'b0;
            m_data_reg     <= 32'd0;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
            s_ready_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            proto_err_reg  <= 1'b0;
`ifdef BCRYPT_LOADER_TIMEOUT_EN
            poll_cnt_reg   <= 16'd0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            word_reg       <= word_next;
            core_reg       <= core_next;
            gap_reg        <= gap_next;
            mem_sel_reg    <= mem_sel_next;
            mem_core_reg   <= mem_core_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_wr_req_reg <= mem_wr_req_next;
            mem_rd_req_reg <= mem_rd_req_next;
            m_data_reg     <= m_data_next;
            m_valid_reg    <= m_valid_next;
            m_last_reg     <= m_last_next;
            s_ready_reg    <= s_ready_next;
            busy_reg       <= busy_next;
            proto_err_reg  <= proto_err_next;
`ifdef BCRYPT_LOADER_TIMEOUT_EN
            poll_cnt_reg   <= poll_cnt_next;
            timeout_reg    <= timeout_next;
`endif
        end
    end

    assign bus.s_ready    = s_ready_reg;
    assign bus.m_data     = m_data_reg;
    assign bus.m_valid    = m_valid_reg;
    assign bus.m_last     = m_last_reg;
    assign bus.mem_sel    = mem_sel_reg;
    assign bus.mem_core   = mem_core_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.mem_wr_req = mem_wr_req_reg;
    assign bus.mem_rd_req = mem_rd_req_reg;
    assign busy           = busy_reg;
    assign proto_err      = proto_err_reg;
`ifdef BCRYPT_LOADER_TIMEOUT_EN
    assign timeout        = timeout_reg;
`else
    assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_bcrypt_job_loader.sv
// Scoreboard bench for bcrypt_job_loader: a memory responder and an output monitor
// check every bus access and result word against expectations queued by the stimulus.
module tb_bcrypt_job_loader;
    localparam int NC = 2;
    localparam int LW = 4;
    localparam int RB = 64;
    localparam int RW = 2;
    localparam int PG = 4;
    localparam int TP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, proto_err, timeout;

    bcrypt_job_loader_if bus_if ();

    bcrypt_job_loader #(
        .NUM_CORES(NC), .LOAD_WORDS(LW), .RESULT_BASE(RB), .RESULT_WORDS(RW),
        .POLL_GAP(PG), .TIMEOUT_POLLS(TP)
    ) dut (
        .Bus2IP_Clk  (clk),
        .Bus2IP_Reset(rst),
        .bus         (bus_if.master),
        .busy        (busy),
        .proto_err   (proto_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 0;
    int last_poll = -1;
    bit stall_toggle = 1'b0;

    logic [47:0] exp_wr_q[$];
    logic [47:0] exp_rd_q[$];
    logic [32:0] exp_out_q[$];
    logic [31:0] poll_resp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] pk(input logic [1:0] s, input int c, input int a, input logic [31:0] d);
        return {s, 7'(c), 7'(a), d};
    endfunction

    // Memory responder: acks after 'lat' extra cycles, checks each access in order.
    initial begin
        int wcnt;
        int rcnt;
        logic [47:0] got;
        wcnt = 0;
        rcnt = 0;
        bus_if.mem_wr_ack = 1'b0;
        bus_if.mem_rd_ack = 1'b0;
        bus_if.mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (bus_if.mem_wr_ack) begin
                bus_if.mem_wr_ack = 1'b0;
            end else if (bus_if.mem_wr_req) begin
                wcnt++;
                if (wcnt > lat) begin
                    wcnt = 0;
                    bus_if.mem_wr_ack = 1'b1;
                    got = {bus_if.mem_sel, bus_if.mem_core, bus_if.mem_addr, bus_if.mem_wdata};
                    $display("wr  sel=%b core=%0d addr=%0d data=%h", bus_if.mem_sel, bus_if.mem_core,
                             bus_if.mem_addr, bus_if.mem_wdata);
                    if (exp_wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %h expected none", got);
                    end else begin
                        check("write", got, exp_wr_q.pop_front());
                    end
                end
            end else begin
                wcnt = 0;
            end

            if (bus_if.mem_rd_ack) begin
                bus_if.mem_rd_ack = 1'b0;
            end else if (bus_if.mem_rd_req) begin
                rcnt++;
                if (rcnt > lat) begin
                    rcnt = 0;
                    bus_if.mem_rd_ack = 1'b1;
                    got = {bus_if.mem_sel, bus_if.mem_core, bus_if.mem_addr, 32'h0};
                    if (bus_if.mem_sel == 2'b01) begin
                        bus_if.mem_rdata = (poll_resp_q.size() != 0) ? poll_resp_q.pop_front() : 32'h0;
                        if (last_poll >= 0) begin
                            checks++;
                            if (cyc - last_poll <= PG) begin
                                errors++;
                                $display("FAIL poll_spacing: got %0d cycles expected more than %0d",
                                         cyc - last_poll, PG);
                            end
                        end
                        last_poll = cyc;
                    end else begin
                        bus_if.mem_rdata = 32'hA0 + 32'(bus_if.mem_core) * 2 + 32'(bus_if.mem_addr) - RB;
                    end
                    $display("rd  sel=%b core=%0d addr=%0d data=%h", bus_if.mem_sel, bus_if.mem_core,
                             bus_if.mem_addr, bus_if.mem_rdata);
                    if (exp_rd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: got %h expected none", got);
                    end else begin
                        check("read", got, exp_rd_q.pop_front());
                    end
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // Output monitor: drives m_ready and checks every presented word, stalled or not.
    initial begin
        bus_if.m_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus_if.m_ready = stall_toggle ? ~bus_if.m_ready : 1'b1;
            if (bus_if.m_valid) begin
                if (exp_out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", {bus_if.m_last, bus_if.m_data});
                end else begin
                    check("out_word", {15'd0, bus_if.m_last, bus_if.m_data}, {15'd0, exp_out_q[0]});
                    if (bus_if.m_ready) begin
                        $display("out data=%h last=%b", bus_if.m_data, bus_if.m_last);
                        void'(exp_out_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        bus_if.s_data  = d;
        bus_if.s_last  = last;
        bus_if.s_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = bus_if.s_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        $display("in  data=%h last=%b", d, last);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: got no s_ready expected accept of %h", d);
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("job_done_busy", 48'(busy), 48'd0);
    endtask

    // Queue the whole expected bus/output trace of one job.
    task automatic setup_job(input logic [31:0] base, input int n_busy_polls, input bit finish);
        for (int i = 0; i < NC * LW; i++)
            exp_wr_q.push_back(pk(2'b10, i / LW, i % LW, base + 32'(i)));
        exp_wr_q.push_back(pk(2'b01, 0, 0, 32'h1));
        for (int p = 0; p < n_busy_polls; p++) begin
            poll_resp_q.push_back(32'h0);
            exp_rd_q.push_back(pk(2'b01, 0, 1, 32'h0));
        end
        if (finish) begin
            poll_resp_q.push_back(32'hFF);
            exp_rd_q.push_back(pk(2'b01, 0, 1, 32'h0));
            for (int c = 0; c < NC; c++) begin
                for (int w = 0; w < RW; w++) begin
                    exp_rd_q.push_back(pk(2'b10, c, RB + w, 32'h0));
                    exp_out_q.push_back({(c == NC - 1) && (w == RW - 1), 32'hA0 + 32'(c * 2 + w)});
                end
            end
        end
        last_poll = -1;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_writes_left"}, 48'(exp_wr_q.size()), 48'd0);
        check({tag, "_reads_left"}, 48'(exp_rd_q.size()), 48'd0);
        check({tag, "_outputs_left"}, 48'(exp_out_q.size()), 48'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.s_data  = 32'd0;
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctrl",
              48'({bus_if.s_ready, bus_if.m_valid, bus_if.m_last, bus_if.mem_wr_req,
                   bus_if.mem_rd_req, busy, proto_err, timeout, bus_if.mem_sel}), 48'd0);
        check("reset_bus", {2'b00, bus_if.mem_core, bus_if.mem_addr, bus_if.mem_wdata}, 48'd0);
        check("reset_m_data", 48'(bus_if.m_data), 48'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 48'({bus_if.s_ready, busy}), 48'b10);

        // Job 1: instant acks, two busy polls, stalling sink.
        lat = 0;
        stall_toggle = 1'b1;
        setup_job(32'd1, 2, 1'b1);
        for (int i = 0; i < NC * LW; i++) send_word(32'd1 + 32'(i), i == NC * LW - 1);
        end_stream();
        wait_idle();
        check("job1_proto_err", 48'(proto_err), 48'd0);
        check_drained("job1");

        // Job 2: slow acks, early s_last on the third word.
        lat = 2;
        stall_toggle = 1'b0;
        setup_job(32'h11, 0, 1'b1);
        for (int i = 0; i < NC * LW; i++) begin
            send_word(32'h11 + 32'(i), i == 2);
            if (i == 2) begin
                #1;
                check("early_last_proto_err", 48'(proto_err), 48'd1);
            end
        end
        end_stream();
        wait_idle();
        check("job2_proto_err", 48'(proto_err), 48'd1);
        check("job2_timeout", 48'(timeout), 48'd0);
        check_drained("job2");

        // Job 3: reset while a load write is waiting for its ack.
        lat = 6;
        send_word(32'h55, 1'b0);
        end_stream();
        @(negedge clk);
        check("midjob_req_held", 48'({bus_if.mem_wr_req, busy}), 48'b11);
        rst = 1'b1;
        @(negedge clk);
        check("midjob_reset_drop",
              48'({bus_if.mem_wr_req, bus_if.mem_rd_req, busy, proto_err, bus_if.mem_sel}), 48'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("after_reset_idle",
              48'({bus_if.s_ready, busy, bus_if.mem_wr_req, bus_if.mem_rd_req}), 48'b1000);

`ifdef BCRYPT_LOADER_TIMEOUT_EN
        // Job 4: status never completes, loader must give up after TP polls.
        lat = 0;
        setup_job(32'h21, TP, 1'b0);
        for (int i = 0; i < NC * LW; i++) send_word(32'h21 + 32'(i), i == NC * LW - 1);
        end_stream();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (timeout) break;
        end
        check("timeout_set", 48'(timeout), 48'd1);
        repeat (20) @(negedge clk);
        check("fault_hold",
              48'({timeout, busy, bus_if.mem_wr_req, bus_if.mem_rd_req, bus_if.mem_sel}), 48'b110000);
        check_drained("job4");
        rst = 1'b1;
        @(negedge clk);
        check("timeout_cleared", 48'({timeout, busy}), 48'd0);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcrypt_job_loader.md
# bcrypt_job_loader

Job sequencer upstream of the bcrypt user-logic block. Accepts a stream of 32-bit setting words, writes them into every core's RAM through the slave memory port, starts all cores via handshake word 0, polls handshake word 1 for the all-done marker, then reads back each core's result words as an output stream. It replaces per-word CPU programming with a single streamed job.

## Interface
- NUM_CORES, 28, cores per job; core index width is 7 bits.
- LOAD_WORDS, 64, words loaded per core at word addresses 0..LOAD_WORDS-1; must be 1..128.
- RESULT_BASE, 64, first result word address per core.
- RESULT_WORDS, 6, result words per core; RESULT_BASE+RESULT_WORDS must be at most 128.
- POLL_GAP, 16, idle cycles between status polls; must be at least 1.
- TIMEOUT_POLLS, 65535, poll-count limit (only with the timeout macro).

Ports:
- Bus2IP_Clk  in  1  clock for all logic.
- Bus2IP_Reset  in  1  reset, synchronous, active-high.
- s_data  in  32  load word.
- s_valid  in  1  load word valid.
- s_last  in  1  marks the final load word of the job.
- s_ready  out  1  load word accepted when s_valid && s_ready.
- m_data  out  32  result word.
- m_valid  out  1  result word valid.
- m_last  out  1  final result word of the job.
- m_ready  in  1  result sink ready.
- mem_sel  out  2  2'b01 = handshake space, 2'b10 = core RAM space, 0 = idle.
- mem_core  out  7  core index (RAM space).
- mem_addr  out  7  word address.
- mem_wdata  out  32  write data.
- mem_wr_req  out  1  write request, held until mem_wr_ack.
- mem_wr_ack  in  1  write done, 1-cycle pulse.
- mem_rd_req  out  1  read request, held until mem_rd_ack.
- mem_rd_ack  in  1  read data valid, 1-cycle pulse.
- mem_rdata  in  32  read data, sampled on mem_rd_ack.
- busy  out  1  high in any state except IDLE.
- proto_err  out  1  sticky: s_last on the wrong word, or s_last missing on the final word.
- timeout  out  1  sticky poll timeout (0 without the macro).

## Operation
- States: IDLE, LOAD_WAIT, LOAD_WR, START, POLL_GAP, POLL_RD, DRAIN_RD, DRAIN_OUT, FAULT.
- IDLE: s_ready=1. Accepting a word captures it, sets word=0 and core=0, and moves to LOAD_WR.
- LOAD_WR: drives mem_sel=2'b10, mem_core=core, mem_addr=word, mem_wdata=the captured word, mem_wr_req=1.
  - On mem_wr_ack, word increments; at LOAD_WORDS-1 it wraps to 0 and core increments.
  - After the write of (NUM_CORES-1, LOAD_WORDS-1), go to START; otherwise go to LOAD_WAIT.
- LOAD_WAIT: s_ready=1 and there is no bus request. Accepting a word captures it and moves to LOAD_WR.
- Load stream order is core-major: NUM_CORES*LOAD_WORDS words in total.
- s_last checking:
  - s_last seen before the final word sets proto_err; loading continues until the full count is reached.
  - s_last absent on the final word also sets proto_err.
- START: writes 32'h1 to mem_sel=2'b01, mem_addr=0. Loading handshake word 0 clears the downstream status word 1. On ack go to POLL_GAP.
- POLL_GAP: counts POLL_GAP cycles, then goes to POLL_RD.
- POLL_RD: reads mem_sel=2'b01, mem_addr=1.
  - mem_rdata==32'hFF: go to DRAIN_RD with core=0, word=0.
  - Any other value: go back to POLL_GAP.
- DRAIN_RD: reads mem_sel=2'b10 at mem_core=core, mem_addr=RESULT_BASE+word. On ack, registers the data and goes to DRAIN_OUT.
- DRAIN_OUT: m_valid=1 and m_data holds the registered word.
  - m_last=1 only on the final (NUM_CORES-1, RESULT_WORDS-1) word.
  - On m_ready, advance the indices (same wrap rule as load) and go to DRAIN_RD, or to IDLE after the last word.
- At most one of mem_wr_req and mem_rd_req is high at a time. mem_sel=0 whenever neither is high.
- Request outputs are registered. A request must not change while waiting for its ack.
- Acks arriving with no request outstanding are ignored.
- proto_err and timeout clear only on reset.

## Timing
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=0, mem_sel=0, mem_core=0, mem_addr=0, mem_wdata=0, mem_wr_req=0, mem_rd_req=0, busy=0, proto_err=0, timeout=0; state=IDLE.
- s_ready rises on the first cycle after reset deasserts.
- Reset asserted mid-job:
  - On the next edge, all requests drop and state returns to IDLE.
  - No partial handshake write is reissued.
- Load throughput is at best one word per 2 cycles plus ack latency: an accept cycle, then a request held until ack.
- Request-to-ack latency is unbounded; mem_wr_req and mem_rd_req deassert in the cycle after the ack is seen.
- Poll spacing is POLL_GAP idle cycles plus the read latency.
- DRAIN_OUT holds m_data/m_last stable while m_valid && !m_ready.
- Minimum drain rate is one word per 2 cycles plus read latency.

## Configuration
- BCRYPT_LOADER_TIMEOUT_EN defined:
  - A 16-bit counter counts POLL_RD reads that do not return 32'hFF.
  - On reaching TIMEOUT_POLLS it sets timeout and moves to FAULT. FAULT holds busy=1 and issues no requests; only reset exits it.
  - The counter clears in START.
- Undefined: no counter; POLL_GAP/POLL_RD loop forever; timeout tied to 0; FAULT is unreachable.

## Test plan
- Reset → every output at its reset value; after release, s_ready=1 and busy=0.
- NUM_CORES=2, LOAD_WORDS=4, instant acks; stream 1..8 with s_last on 8 → writes (core0,a0..3)=1..4 and (core1,a0..3)=5..8, then a handshake write of 1 at addr 0, proto_err=0.
- Polls return 0, 0, then 32'hFF → exactly 3 reads at addr 1, spaced ≥POLL_GAP cycles, then result reads begin at RESULT_BASE.
- RESULT_WORDS=2; model returns 32'hA0+core*2+word; m_ready toggles 1/0 → output A0, A1, A2, A3 with m_last only on A3; data held while stalled.
- s_last on word 3 of 8 → proto_err=1; load continues and 8 writes still occur.
- Macro defined, TIMEOUT_POLLS=3, status never 32'hFF → timeout=1 after the 3rd poll, no further requests; reset clears it.
